// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown-timer control slice.
// Imported by timer_ctrl and its testbench.
package timer_pkg;

    localparam int TIME_W      = 6;
    localparam int LOAD_CYCLES = 2;
    localparam int LOAD_W      = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOADING = 3'd1,
        ST_READY   = 3'd2,
        ST_RUNNING = 3'd3,
        ST_PAUSED  = 3'd4,
        ST_ALARM   = 3'd5
    } state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one push-button level, one request per press.
// With TIMER_CTRL_SYNC_EN defined the button first passes a 2-flop synchronizer.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);

    logic w_level;
    logic r_prev;

`ifdef TIMER_CTRL_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    assign w_level = r_sync[1];
`else
    assign w_level = i_btn;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/timer_ctrl.sv
// Button-driven control FSM for a 6-bit countdown timer: load/run strobes and alarm.
// Define TIMER_CTRL_SYNC_EN to synchronize the buttons (adds 2 cycles of latency).
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_load,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              done,
    input  logic [TIME_W-1:0] time_left,
    output logic              load,
    output logic              run,
    output logic              alarm,
    output logic [2:0]        state
);

    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int ALARM_W = $clog2(ALARM_TICKS + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_TICKS - 1);
    localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(LOAD_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [TICK_W-1:0]   r_tick;
    logic [ALARM_W-1:0]  r_alarmCnt;
    logic [LOAD_W-1:0]   r_loadCnt;
    logic                r_load;
    logic                r_run;
    logic                r_alarm;
    logic                w_loadNxt;
    logic                w_runNxt;
    logic                w_alarmNxt;
    logic                w_loadRise;
    logic                w_startRise;
    logic                w_stopRise;
    logic                w_loadReq;
    logic                w_stopReq;
    logic                w_startReq;
    logic                w_tickWrap;
    logic                w_loadDone;
    logic                w_alarmDone;

    btn_edge u_loadEdge  (.clk(clk), .reset(reset), .i_btn(btn_load),  .o_rise(w_loadRise));
    btn_edge u_startEdge (.clk(clk), .reset(reset), .i_btn(btn_start), .o_rise(w_startRise));
    btn_edge u_stopEdge  (.clk(clk), .reset(reset), .i_btn(btn_stop),  .o_rise(w_stopRise));

    // Simultaneous presses resolve as load > stop > start.
    assign w_loadReq  = w_loadRise;
    assign w_stopReq  = w_stopRise & ~w_loadRise;
    assign w_startReq = w_startRise & ~w_loadRise & ~w_stopRise;

    assign w_tickWrap  = (r_tick == TICK_LAST);
    assign w_loadDone  = (r_loadCnt == LOAD_LAST);
    assign w_alarmDone = w_tickWrap && (r_alarmCnt == ALARM_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_load  <= 1'b0;
            r_run   <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_next;
            r_load  <= w_loadNxt;
            r_run   <= w_runNxt;
            r_alarm <= w_alarmNxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_loadReq) w_next = ST_LOADING;
            end
            ST_LOADING: begin
                if (w_loadDone) w_next = ST_READY;
            end
            ST_READY: begin
                if (w_loadReq)                                  w_next = ST_LOADING;
                else if (w_startReq && (time_left != '0))       w_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (w_loadReq)      w_next = ST_LOADING;
                else if (w_stopReq) w_next = ST_PAUSED;
                else if (done)      w_next = ST_ALARM;
            end
            ST_PAUSED: begin
                if (w_loadReq)       w_next = ST_LOADING;
                else if (w_startReq) w_next = ST_RUNNING;
            end
            ST_ALARM: begin
                if (w_loadReq)                     w_next = ST_LOADING;
                else if (w_stopReq || w_alarmDone) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A wrap that coincides with leaving RUNNING is dropped so run never overlaps load or PAUSED.
    always_comb begin
        w_loadNxt  = (w_next == ST_LOADING);
        w_runNxt   = (r_state == ST_RUNNING) && (w_next == ST_RUNNING) && w_tickWrap;
        w_alarmNxt = (w_next == ST_ALARM);
    end

    // Tick restarts on ALARM entry so the alarm lasts exactly ALARM_TICKS full strobe periods.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick <= '0;
        end else if ((w_next == ST_LOADING) || (r_state == ST_READY) ||
                     ((r_state == ST_RUNNING) && (w_next == ST_ALARM))) begin
            r_tick <= '0;
        end else if ((r_state == ST_RUNNING) || (r_state == ST_ALARM)) begin
            r_tick <= w_tickWrap ? '0 : r_tick + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alarmCnt <= '0;
            r_loadCnt  <= '0;
        end else begin
            if (r_state != ST_ALARM) begin
                r_alarmCnt <= '0;
            end else if (w_tickWrap) begin
                r_alarmCnt <= r_alarmCnt + ALARM_W'(1);
            end
            r_loadCnt <= ((r_state == ST_LOADING) && !w_loadDone) ? r_loadCnt + LOAD_W'(1) : '0;
        end
    end

    assign load  = r_load;
    assign run   = r_run;
    assign alarm = r_alarm;
    assign state = r_state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl with TICK_DIV=4, ALARM_TICKS=2.
// Table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnLoad, btnStart, btnStop, done;
    logic [5:0] timeLeft;
    logic       load, run, alarm;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ld, st, sp, dn;
        logic [5:0] tl;
        logic [5:0] expOut;
    } vec_t;

    vec_t vecs[$];

    timer_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
        .clk(clk), .reset(reset),
        .btn_load(btnLoad), .btn_start(btnStart), .btn_stop(btnStop),
        .done(done), .time_left(timeLeft),
        .load(load), .run(run), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Load and run must never overlap, checked every cycle away from the edge.
    always @(negedge clk) begin
        checks++;
        if (load && run) begin
            errors++;
            $display("[TB] FAIL loadRunOverlap: load=%b run=%b, required not both high", load, run);
        end
    end

    function automatic vec_t makeVec(logic ld, logic st, logic sp, logic dn, logic [5:0] tl,
                                     logic eLd, logic eRun, logic eAl, logic [2:0] eSt);
        vec_t v;
        v.ld = ld; v.st = st; v.sp = sp; v.dn = dn; v.tl = tl;
        v.expOut = {eLd, eRun, eAl, eSt};
        return v;
    endfunction

    task automatic applyStimulus(input logic ld, input logic st, input logic sp,
                                 input logic dn, input logic [5:0] tl);
        btnLoad = ld; btnStart = st; btnStop = sp; done = dn; timeLeft = tl;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expOut);
        logic [5:0] got;
        got = {load, run, alarm, state};
        checks++;
        if (got !== expOut) begin
            errors++;
            $display("[TB] FAIL %s: load/run/alarm/state got %b/%b/%b/%0d required %b/%b/%b/%0d",
                     name, got[5], got[4], got[3], got[2:0],
                     expOut[5], expOut[4], expOut[3], expOut[2:0]);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int expVal);
        checks++;
        if (got != expVal) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, expVal);
        end
    endtask

    initial begin
        int loadCount;
        bit seen;

        // ld st sp dn tl -> load run alarm state
        vecs.push_back(makeVec(0,1,0,0,3, 0,0,0,0)); // start ignored in IDLE
        vecs.push_back(makeVec(0,0,1,0,3, 0,0,0,0)); // stop ignored in IDLE
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,0));
        vecs.push_back(makeVec(1,0,0,0,3, 1,0,0,1));
        vecs.push_back(makeVec(1,0,0,0,3, 1,0,0,1));
        vecs.push_back(makeVec(1,0,0,0,3, 0,0,0,2));
        vecs.push_back(makeVec(1,0,0,0,3, 0,0,0,2));
        vecs.push_back(makeVec(0,0,0,0,0, 0,0,0,2));
        vecs.push_back(makeVec(0,1,0,0,0, 0,0,0,2)); // start with time_left=0 ignored
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,2));
        vecs.push_back(makeVec(0,1,0,0,3, 0,0,0,3)); // RUNNING entered
        vecs.push_back(makeVec(0,1,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,0,0,3, 0,1,0,3)); // first run, 4 cycles after entry
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,1,0,3, 0,0,0,4)); // stop 2 cycles after run
        vecs.push_back(makeVec(0,0,1,0,3, 0,0,0,4));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,4));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,4));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,4));
        vecs.push_back(makeVec(0,1,0,0,3, 0,0,0,3)); // resume
        vecs.push_back(makeVec(0,0,0,0,3, 0,1,0,3)); // run 2 cycles after start edge
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,0,0,3, 0,0,0,3));
        vecs.push_back(makeVec(0,0,0,0,3, 0,1,0,3));
        vecs.push_back(makeVec(0,0,0,1,0, 0,0,1,5)); // done -> ALARM next cycle
        for (int i = 0; i < 7; i++) vecs.push_back(makeVec(0,0,0,0,0, 0,0,1,5));
        vecs.push_back(makeVec(0,0,0,0,0, 0,0,0,0)); // 8 alarm cycles then IDLE
        vecs.push_back(makeVec(0,0,0,0,0, 0,0,0,0));

        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 6'd3);
        repeat (2) stepCycle();
        checkOutput("resetState", 6'b000_000);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput($sformatf("idle%0d", i), 6'b000_000);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].dn, vecs[i].tl);
            stepCycle();
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
        end

        $display("[TB] holding load for 10 cycles");
        loadCount = 0;
        applyStimulus(1, 0, 0, 0, 6'd3);
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (load) loadCount++;
        end
        checkValue("holdLoadPulseCycles", loadCount, 2);
        checkValue("holdLoadState", int'(state), 2);
        applyStimulus(0, 0, 0, 0, 6'd3);
        stepCycle();

        $display("[TB] simultaneous edges while running");
        applyStimulus(0, 1, 0, 0, 6'd3);
        stepCycle();
        checkOutput("simRunning", 6'b000_011);
        applyStimulus(0, 0, 0, 0, 6'd3);
        stepCycle();
        applyStimulus(1, 1, 1, 0, 6'd3);
        stepCycle();
        checkOutput("simLoad1", 6'b100_001);
        applyStimulus(0, 0, 0, 0, 6'd3);
        stepCycle();
        checkOutput("simLoad2", 6'b100_001);
        stepCycle();
        checkOutput("simReady", 6'b000_010);

        $display("[TB] alarm acknowledged by stop");
        applyStimulus(0, 1, 0, 0, 6'd3);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 6'd3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            stepCycle();
            if (run) seen = 1'b1;
        end
        checkValue("runWithinBudget", int'(seen), 1);
        applyStimulus(0, 0, 0, 1, 6'd0);
        stepCycle();
        checkOutput("alarmEnter", 6'b001_101);
        applyStimulus(0, 0, 0, 0, 6'd0);
        repeat (2) stepCycle();
        checkOutput("alarmHeld", 6'b001_101);
        applyStimulus(0, 0, 1, 0, 6'd0);
        stepCycle();
        checkOutput("alarmStopped", 6'b000_000);
        applyStimulus(0, 0, 0, 0, 6'd3);
        stepCycle();

        $display("[TB] async reset during load");
        applyStimulus(1, 0, 0, 0, 6'd3);
        stepCycle();
        checkOutput("preResetLoad", 6'b100_001);
        #2;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 6'd3);
        #1;
        checkOutput("resetMidLoad", 6'b000_000);
        stepCycle();
        reset = 1'b1;
        stepCycle();
        checkOutput("afterReset", 6'b000_000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
